rcvbuffer: RTL and testbench
============================

// Module: rcvbuffer
// PURPOSE
//  Receive-side buffer feeding the comm loopback. Accepts NUM_BYTES bytes from buffer_control over a 4-phase dav/rfd/ack handshake.
//  Stores the bytes in on-chip RAM, then streams them out serially, one bit per clk_1200 cycle, LSB of byte 0 first.
//  Pulses start on the first bit; this start is the signal txmitbuffer uses to time its LATENCY delay.
// PARAMETERS
//  NUM_BYTES  1250  bytes per frame (10000 bits); legal range 2..2047
//  AW         11    address/byte-counter width; must be >= clog2(NUM_BYTES)
// PORTS
//  clk_1200   in   1  1200 Hz system clock; all logic on posedge
//  reset_n    in   1  asynchronous, active-low reset
//  dav_rx     in   1  buffer_control: datain is valid
//  datain     in   8  byte from buffer_control
//  rfd_rx     out  1  ready for data
//  ack_rx     out  1  byte accepted
//  rx_full    out  1  frame loaded; high until the last bit has been sent
//  rx_empty   out  1  buffer drained / nothing loaded
//  start      out  1  1-cycle pulse coincident with the first serial bit
//  dout_valid out  1  dataout carries a frame bit this cycle
//  dataout    out  1  serial bitstream to comm loopback
// BEHAVIOUR
//  Reset (async assert, sync release): state=FILL, byte_cnt=0, bit_idx=0.
//   Outputs at reset: rfd_rx=1, ack_rx=0, rx_full=0, rx_empty=1, start=0, dout_valid=0, dataout=0. RAM contents don't-care.
//  FILL: rfd_rx=1.
//   On a posedge with dav_rx&rfd_rx: write datain to RAM[byte_cnt], byte_cnt++, rx_empty<=0, rfd_rx<=0, ack_rx<=1 -> ACK.
//  ACK: hold ack_rx=1 and rfd_rx=0 until dav_rx is sampled low; then ack_rx<=0.
//   If byte_cnt<NUM_BYTES: rfd_rx<=1 -> FILL.
//   Otherwise: rx_full<=1, byte_cnt<=0, issue RAM read of addr 0 -> LOAD.
//  LOAD (1 cycle): capture RAM data into an 8-bit shift register and prefetch addr 1 -> SEND.
//  SEND: the registered outputs follow this sequence.
//   First SEND cycle: start=1, dout_valid=1, dataout=byte0[0].
//   Bits go out LSB-first with no gaps. bit_idx 0..7; at bit_idx==7 the prefetched byte loads and byte_cnt++.
//   Exactly NUM_BYTES*8 consecutive dout_valid cycles.
//  After the last bit (byte NUM_BYTES-1, bit 7), on the next cycle:
//   dout_valid=0, dataout=0, rx_full=0, rx_empty=1, byte_cnt=0, rfd_rx=1 -> FILL.
//  start is high for exactly one cycle per frame and never outside SEND.
//  During LOAD/SEND: rfd_rx=0. dav_rx is ignored and no write occurs, including when dav_rx is held high.
//  dav_rx held high across the ACK->FILL return: the next byte is accepted only after dav_rx has been seen low (4-phase). No double-accept.
//  datain changes while ack_rx=1 are ignored; the value is latched only on the accept edge.
//  Counters: byte_cnt is AW bits and never wraps past NUM_BYTES. bit_idx is 3 bits and wraps 7->0.
//  reset_n asserted mid-fill or mid-send: the frame is abandoned immediately and all outputs take reset values. No partial resume.
//  Total latency: end of the last ack (dav_rx low sampled) -> start high = 2 cycles (ACK exit, LOAD).
// STRUCTURE
//  rcvbuffer_pkg: state encoding (FILL, ACK, LOAD, SEND), default NUM_BYTES, BITS_PER_BYTE=8.
//  Sub-module rcvbuffer_ram: single-port NUM_BYTES x 8 synchronous RAM, 1-cycle registered read.
//   Write port used in FILL/ACK, read port used in LOAD/SEND.
//  Top: FSM, byte_cnt, bit_idx, shift register, handshake and status registers.
// TESTING (NUM_BYTES=4 unless stated)
//  1 Reset: reset_n=0 mid-run -> rfd_rx=1, rx_empty=1, everything else 0, asynchronously (before the next edge).
//  2 Fill/send: bytes 8'hA5,8'h3C,8'hFF,8'h01 with a clean handshake.
//    -> rx_full=1; start 2 cycles after the final dav_rx drop.
//    -> dataout = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1x8, 1,0x7: 32 contiguous dout_valid cycles.
//    -> then rx_empty=1, rfd_rx=1.
//  3 Handshake: dav_rx held high for 5 cycles -> exactly one write; ack_rx stays high until dav_rx drops.
//    -> datain changed while ack high does not corrupt the stored byte.
//  4 Busy ignore: pulse dav_rx with 8'h77 during SEND -> no write, rfd_rx=0, serial stream unchanged. Next frame is accepted normally.
//  5 Mid-send reset: assert reset_n=0 at bit 13, release, then send a new frame 8'h00,8'h00,8'h00,8'h80.
//    -> exactly one start pulse, at the new frame's first bit; output matches the new frame only.
//  6 Full size: NUM_BYTES=1250, random bytes -> 10000 serial bits match the scoreboard, one start pulse, rx_empty after the final bit.

Source files
------------

// File: rtl/rcvbuffer_pkg.sv
`default_nettype none
//==============================================================================
// Module   : rcvbuffer_pkg
// Brief    : State encoding and shared constants for the receive buffer.
// Revision : 1.0
//==============================================================================
package rcvbuffer_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_ACK  = 2'd1,
        ST_LOAD = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_NUM_BYTES = 1250;
    localparam int unsigned BITS_PER_BYTE     = 8;

endpackage
`default_nettype wire

// File: rtl/rcvbuffer_ram.sv
`default_nettype none
//==============================================================================
// Module   : rcvbuffer_ram
// Brief    : Single-port DEPTH x 8 synchronous RAM with a registered read.
// Revision : 1.0
//==============================================================================
module rcvbuffer_ram
    import rcvbuffer_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_NUM_BYTES,
    parameter int unsigned AW    = 11
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [AW-1:0]            addr_i,
    input  logic [BITS_PER_BYTE-1:0] wdata_i,
    output logic [BITS_PER_BYTE-1:0] rdata_o
);

    logic [BITS_PER_BYTE-1:0] mem_q [DEPTH];
    logic [BITS_PER_BYTE-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/rcvbuffer.sv
`default_nettype none
//==============================================================================
// Module   : rcvbuffer
// Brief    : Loads a frame of NUM_BYTES bytes over a 4-phase dav/rfd/ack
//            handshake, then streams it out serially LSB-first with a start pulse.
// Revision : 1.0
//==============================================================================
module rcvbuffer
    import rcvbuffer_pkg::*;
#(
    parameter int unsigned NUM_BYTES = DEFAULT_NUM_BYTES,
    parameter int unsigned AW        = 11
) (
    input  logic                     clk_1200,
    input  logic                     reset_n,
    input  logic                     dav_rx,
    input  logic [BITS_PER_BYTE-1:0] datain,
    output logic                     rfd_rx,
    output logic                     ack_rx,
    output logic                     rx_full,
    output logic                     rx_empty,
    output logic                     start,
    output logic                     dout_valid,
    output logic                     dataout
);

    localparam logic [AW-1:0] C_NUM      = AW'(NUM_BYTES);
    localparam logic [AW-1:0] C_LAST     = AW'(NUM_BYTES - 1);
    localparam logic [AW-1:0] C_ONE      = AW'(1);
    localparam logic [2:0]    C_LAST_BIT = 3'(BITS_PER_BYTE - 1);

    state_t                   state_q,    state_d;
    logic [AW-1:0]            byte_cnt_q, byte_cnt_d;
    logic [2:0]               bit_idx_q,  bit_idx_d;
    logic [BITS_PER_BYTE-1:0] shift_q,    shift_d;
    logic                     rfd_q,      rfd_d;
    logic                     ack_q,      ack_d;
    logic                     full_q,     full_d;
    logic                     empty_q,    empty_d;
    logic                     start_q,    start_d;
    logic                     valid_q,    valid_d;

    logic                     ram_we;
    logic [AW-1:0]            ram_addr;
    logic [BITS_PER_BYTE-1:0] ram_rdata;

    rcvbuffer_ram #(
        .DEPTH (NUM_BYTES),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk_1200),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (datain),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_1200 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_FILL;
            byte_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            rfd_q      <= 1'b1;
            ack_q      <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            start_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rfd_q      <= rfd_d;
            ack_q      <= ack_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            start_q    <= start_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        rfd_d      = rfd_q;
        ack_d      = ack_q;
        full_d     = full_q;
        empty_d    = empty_q;
        start_d    = 1'b0;
        valid_d    = valid_q;
        ram_we     = 1'b0;
        ram_addr   = byte_cnt_q;

        unique case (state_q)
            ST_FILL: begin
                if (dav_rx && rfd_q) begin
                    ram_we     = 1'b1;
                    byte_cnt_d = byte_cnt_q + C_ONE;
                    empty_d    = 1'b0;
                    rfd_d      = 1'b0;
                    ack_d      = 1'b1;
                    state_d    = ST_ACK;
                end
            end

            ST_ACK: begin
                // Address 0 is presented here so byte 0 is ready by the end of LOAD.
                ram_addr = '0;
                if (!dav_rx) begin
                    ack_d = 1'b0;
                    if (byte_cnt_q < C_NUM) begin
                        rfd_d   = 1'b1;
                        state_d = ST_FILL;
                    end else begin
                        full_d     = 1'b1;
                        byte_cnt_d = '0;
                        state_d    = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                ram_addr  = C_ONE;
                shift_d   = ram_rdata;
                valid_d   = 1'b1;
                start_d   = 1'b1;
                bit_idx_d = '0;
                state_d   = ST_SEND;
            end

            ST_SEND: begin
                // The RAM read register doubles as the prefetch of the next byte.
                ram_addr = (byte_cnt_q == C_LAST) ? '0 : byte_cnt_q + C_ONE;
                if (bit_idx_q == C_LAST_BIT) begin
                    bit_idx_d = '0;
                    if (byte_cnt_q == C_LAST) begin
                        shift_d    = '0;
                        valid_d    = 1'b0;
                        full_d     = 1'b0;
                        empty_d    = 1'b1;
                        byte_cnt_d = '0;
                        rfd_d      = 1'b1;
                        state_d    = ST_FILL;
                    end else begin
                        shift_d    = ram_rdata;
                        byte_cnt_d = byte_cnt_q + C_ONE;
                    end
                end else begin
                    shift_d   = {1'b0, shift_q[BITS_PER_BYTE-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    assign rfd_rx     = rfd_q;
    assign ack_rx     = ack_q;
    assign rx_full    = full_q;
    assign rx_empty   = empty_q;
    assign start      = start_q;
    assign dout_valid = valid_q;
    assign dataout    = shift_q[0];

endmodule
`default_nettype wire

// File: tb/tb_rcvbuffer.sv
`default_nettype none
//==============================================================================
// Module   : tb_rcvbuffer
// Brief    : Scoreboard bench for rcvbuffer (4-byte and 1250-byte instances).
// Revision : 1.0
//==============================================================================
module tb_rcvbuffer;

    typedef struct packed {
        logic b;
        logic st;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      dav_v;
    logic [1:0][7:0] din_v;

    logic rfd0, ack0, full0, empty0, start0, dv0, dout0;
    logic rfd1, ack1, full1, empty1, start1, dv1, dout1;
    logic [1:0] rfd_v, ack_v, full_v, empty_v, start_v, dv_v, dout_v;

    exp_t q0[$];
    exp_t q1[$];
    int   checks    = 0;
    int   failures  = 0;
    int   start_cnt [2];

    always #5 clk = ~clk;

    assign rfd_v   = {rfd1, rfd0};
    assign ack_v   = {ack1, ack0};
    assign full_v  = {full1, full0};
    assign empty_v = {empty1, empty0};
    assign start_v = {start1, start0};
    assign dv_v    = {dv1, dv0};
    assign dout_v  = {dout1, dout0};

    rcvbuffer #(.NUM_BYTES(4), .AW(11)) dut (
        .clk_1200   (clk),
        .reset_n    (rst_n),
        .dav_rx     (dav_v[0]),
        .datain     (din_v[0]),
        .rfd_rx     (rfd0),
        .ack_rx     (ack0),
        .rx_full    (full0),
        .rx_empty   (empty0),
        .start      (start0),
        .dout_valid (dv0),
        .dataout    (dout0)
    );

    rcvbuffer #(.NUM_BYTES(1250), .AW(11)) dut_big (
        .clk_1200   (clk),
        .reset_n    (rst_n),
        .dav_rx     (dav_v[1]),
        .datain     (din_v[1]),
        .rfd_rx     (rfd1),
        .ack_rx     (ack1),
        .rx_full    (full1),
        .rx_empty   (empty1),
        .start      (start1),
        .dout_valid (dv1),
        .dataout    (dout1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_bit(input int i, input logic b, input logic st);
        exp_t e;
        e.b  = b;
        e.st = st;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic push_byte(input int i, input logic [7:0] b, input logic first);
        for (int k = 0; k < 8; k++) push_bit(i, b[k], first && (k == 0));
    endtask

    task automatic mon(input int i);
        exp_t e;
        int   qs;
        qs = (i == 0) ? q0.size() : q1.size();
        if (start_v[i]) begin
            chk($sformatf("start_has_valid%0d", i), 32'(dv_v[i]), 32'd1);
            start_cnt[i]++;
        end
        if (dv_v[i]) begin
            if (qs == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_bit%0d: got bit %0b with dout_valid, required no bit", i, dout_v[i]);
            end else begin
                if (i == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("dataout%0d", i), 32'(dout_v[i]), 32'(e.b));
                chk($sformatf("start_pos%0d", i), 32'(start_v[i]), 32'(e.st));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic send_byte(input int i, input logic [7:0] b, input int hold);
        int n;
        n = 0;
        while (!rfd_v[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rfd_ready", 32'(rfd_v[i]), 32'd1);
        dav_v[i] = 1'b1;
        din_v[i] = b;
        @(negedge clk);
        chk("ack_rise", 32'(ack_v[i]), 32'd1);
        for (int h = 0; h < hold; h++) begin
            din_v[i] = ~b;
            @(negedge clk);
            chk("ack_hold", 32'(ack_v[i]), 32'd1);
            chk("rfd_hold", 32'(rfd_v[i]), 32'd0);
        end
        dav_v[i] = 1'b0;
        din_v[i] = 8'h00;
        @(negedge clk);
        chk("ack_fall", 32'(ack_v[i]), 32'd0);
    endtask

    task automatic send_frame4(input logic [31:0] w, input int hold0);
        for (int k = 0; k < 4; k++) push_byte(0, w[31-8*k -: 8], k == 0);
        for (int k = 0; k < 4; k++) send_byte(0, w[31-8*k -: 8], (k == 0) ? hold0 : 0);
    endtask

    task automatic wait_done(input int i, input int budget);
        int n;
        int qs;
        n = 0;
        @(negedge clk);
        while (!(empty_v[i] && rfd_v[i] && !full_v[i] && !dv_v[i]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        qs = (i == 0) ? q0.size() : q1.size();
        chk("frame_in_time", 32'(n < budget), 32'd1);
        chk("queue_drained", 32'(qs), 32'd0);
        chk("end_empty", 32'(empty_v[i]), 32'd1);
        chk("end_rfd", 32'(rfd_v[i]), 32'd1);
        chk("end_dataout", 32'(dout_v[i]), 32'd0);
    endtask

    task automatic chk_reset();
        chk("rst_rfd", 32'(rfd0), 32'd1);
        chk("rst_ack", 32'(ack0), 32'd0);
        chk("rst_full", 32'(full0), 32'd0);
        chk("rst_empty", 32'(empty0), 32'd1);
        chk("rst_start", 32'(start0), 32'd0);
        chk("rst_valid", 32'(dv0), 32'd0);
        chk("rst_dataout", 32'(dout0), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] seq;
        logic [7:0]  rb;
        int          s;
        int          n;

        start_cnt[0] = 0;
        start_cnt[1] = 0;
        rst_n = 1'b1;
        dav_v = '0;
        din_v = '0;
        #2 rst_n = 1'b0;
        #1 chk_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean fill/send of A5,3C,FF,01 against the hand-listed bit order
        seq = 32'b1010_0101_0011_1100_1111_1111_1000_0000;
        for (int k = 0; k < 32; k++) push_bit(0, seq[31-k], k == 0);
        send_byte(0, 8'hA5, 0);
        send_byte(0, 8'h3C, 0);
        send_byte(0, 8'hFF, 0);
        send_byte(0, 8'h01, 0);
        chk("full_after_load", 32'(full0), 32'd1);
        chk("start_latency_1", 32'(start0), 32'd0);
        chk("rfd_in_load", 32'(rfd0), 32'd0);
        @(negedge clk);
        chk("start_latency_2", 32'(start0), 32'd1);
        wait_done(0, 100);

        // dav held 5 cycles with datain toggling while ack is high
        send_frame4(32'h5AC30FF0, 4);
        wait_done(0, 100);

        // dav pulse with 8'h77 while sending must be ignored
        send_frame4(32'h12345678, 0);
        repeat (5) @(negedge clk);
        dav_v[0] = 1'b1;
        din_v[0] = 8'h77;
        repeat (2) begin
            @(negedge clk);
            chk("busy_rfd", 32'(rfd0), 32'd0);
            chk("busy_ack", 32'(ack0), 32'd0);
        end
        dav_v[0] = 1'b0;
        wait_done(0, 100);
        send_frame4(32'h9ABCDEF1, 0);
        wait_done(0, 100);

        // Asynchronous reset in the middle of a fill
        send_byte(0, 8'h11, 0);
        send_byte(0, 8'h22, 0);
        chk("midfill_not_empty", 32'(empty0), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset at bit 13 of a frame, then a fresh frame
        send_frame4(32'hA53CFF01, 0);
        n = 0;
        while (!start0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", 32'(start0), 32'd1);
        repeat (13) @(negedge clk);
        #2 rst_n = 1'b0;
        q0.delete();
        #1 chk_reset();
        @(negedge clk);
        rst_n = 1'b1;
        s = start_cnt[0];
        send_frame4(32'h00000080, 0);
        wait_done(0, 100);
        chk("one_start_after_reset", 32'(start_cnt[0] - s), 32'd1);

        // Full-size frame on the 1250-byte instance
        for (int i = 0; i < 1250; i++) begin
            rb = 8'($urandom);
            push_byte(1, rb, i == 0);
            send_byte(1, rb, 0);
        end
        wait_done(1, 12000);
        chk("big_start_count", 32'(start_cnt[1]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
